// File: rtl/debug_frame_sender_pkg.sv
// ---------------------------------------------------------------------------
// debug_frame_sender_pkg
// Shared types and constants for the debug frame sender.
//   snd_state_t     : sender FSM state encoding (IDLE/SEND/WAIT/DONE)
//   DEF_UART_BITS   : default width of one UART byte
//   DEF_FRAME_BITS  : default width of the full debug frame
//   ceil_div()      : integer ceiling division used to size the byte count
// ---------------------------------------------------------------------------
package debug_frame_sender_pkg;

    typedef enum logic [1:0] {
        SND_IDLE = 2'd0,
        SND_SEND = 2'd1,
        SND_WAIT = 2'd2,
        SND_DONE = 2'd3
    } snd_state_t;

    localparam int DEF_UART_BITS  = 8;
    localparam int DEF_FRAME_BITS = 1024;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/debug_frame_sender.sv
// ---------------------------------------------------------------------------
// debug_frame_sender
// Snapshots a wide debug frame on a start request and streams it through the
// UART transmitter one byte at a time (least significant byte first), using
// a start/done handshake per byte. Pulses o_done once the last byte is out.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   i_start     one-cycle send request (ignored while busy)
//   i_frame     debug frame, captured only when i_start is accepted
//   i_tx_done   UART TX finished the current byte (honoured only in WAIT)
//   o_tx_start  one-cycle pulse telling the UART to send o_tx_data
//   o_tx_data   byte currently being sent, 0 while idle
//   o_busy      high from the accepted start through the DONE cycle
//   o_done      one-cycle pulse after the last byte has completed
// ---------------------------------------------------------------------------
module debug_frame_sender
    import debug_frame_sender_pkg::*;
#(
    parameter int UART_BITS  = DEF_UART_BITS,
    parameter int FRAME_BITS = DEF_FRAME_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [FRAME_BITS-1:0] i_frame,
    input  logic                  i_tx_done,
    output logic                  o_tx_start,
    output logic [UART_BITS-1:0]  o_tx_data,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int N_BYTES  = ceil_div(FRAME_BITS, UART_BITS);
    localparam int CNT_BITS = $clog2(N_BYTES) + 1;
    localparam int PAD_BITS = N_BYTES * UART_BITS;

    snd_state_t            state;
    snd_state_t            next_state;
    logic [PAD_BITS-1:0]   shift_reg;
    logic [PAD_BITS-1:0]   next_shift;
    logic [CNT_BITS-1:0]   count;
    logic [CNT_BITS-1:0]   next_count;
    logic [CNT_BITS-1:0]   count_inc;

    assign count_inc = count + CNT_BITS'(1);

    // State, shift register and byte counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SND_IDLE;
            shift_reg <= '0;
            count     <= '0;
        end else begin
            state     <= next_state;
            shift_reg <= next_shift;
            count     <= next_count;
        end
    end

    // Next-state and output decode. The byte on the wire is always the low
    // byte of the shift register; it only moves when the UART reports done,
    // so it stays stable through the whole WAIT phase.
    always_comb begin
        next_state = state;
        next_shift = shift_reg;
        next_count = count;
        o_tx_start = 1'b0;
        o_tx_data  = shift_reg[UART_BITS-1:0];
        o_busy     = 1'b1;
        o_done     = 1'b0;

        case (state)
            SND_IDLE: begin
                o_busy    = 1'b0;
                o_tx_data = '0;
                if (i_start) begin
                    // Zero-extension supplies the padding of the last byte.
                    next_shift = PAD_BITS'(i_frame);
                    next_count = '0;
                    next_state = SND_SEND;
                end
            end
            SND_SEND: begin
                o_tx_start = 1'b1;
                next_state = SND_WAIT;
            end
            SND_WAIT: begin
                if (i_tx_done) begin
                    next_shift = shift_reg >> UART_BITS;
                    next_count = count_inc;
                    next_state = (count_inc == CNT_BITS'(N_BYTES)) ? SND_DONE : SND_SEND;
                end
            end
            SND_DONE: begin
                o_done     = 1'b1;
                next_state = SND_IDLE;
            end
            default: begin
                next_state = SND_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_debug_frame_sender.sv
// ---------------------------------------------------------------------------
// tb_debug_frame_sender
// Directed bench for debug_frame_sender. Two instances are used: a 24-bit
// frame (three full bytes) and a 20-bit frame (last byte padded). A table of
// frames with UART turnaround delays and expected bytes / o_done cycle is
// replayed, plus a hand-written reset-in-the-middle sequence.
// ---------------------------------------------------------------------------
module tb_debug_frame_sender;

    logic        clk;
    logic        rst;
    logic        start24;
    logic        start20;
    logic        tx_done;
    logic [23:0] frame24;
    logic [19:0] frame20;

    logic        tx_start24, busy24, done24;
    logic [7:0]  tx_data24;
    logic        tx_start20, busy20, done20;
    logic [7:0]  tx_data20;

    logic        sel;
    logic        m_tx_start, m_busy, m_done;
    logic [7:0]  m_tx_data;

    int total;
    int bad;

    debug_frame_sender #(.UART_BITS(8), .FRAME_BITS(24)) dut24 (
        .clk        (clk),
        .rst        (rst),
        .i_start    (start24),
        .i_frame    (frame24),
        .i_tx_done  (tx_done),
        .o_tx_start (tx_start24),
        .o_tx_data  (tx_data24),
        .o_busy     (busy24),
        .o_done     (done24)
    );

    debug_frame_sender #(.UART_BITS(8), .FRAME_BITS(20)) dut20 (
        .clk        (clk),
        .rst        (rst),
        .i_start    (start20),
        .i_frame    (frame20),
        .i_tx_done  (tx_done),
        .o_tx_start (tx_start20),
        .o_tx_data  (tx_data20),
        .o_busy     (busy20),
        .o_done     (done20)
    );

    // 100 MHz-style free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Route the instance under test to a common set of monitor signals.
    always_comb begin
        m_tx_start = sel ? tx_start20 : tx_start24;
        m_tx_data  = sel ? tx_data20  : tx_data24;
        m_busy     = sel ? busy20     : busy24;
        m_done     = sel ? done20     : done24;
    end

    typedef struct {
        logic        sel;        // 0: 24-bit instance, 1: 20-bit instance
        logic [23:0] frame;
        int          delay;      // cycles from o_tx_start to i_tx_done
        logic        poke;       // extra starts mid-frame and in DONE
        logic        stray;      // i_tx_done in IDLE and in every SEND cycle
        logic [23:0] exp;        // expected bytes, exp[7:0] sent first
        int          exp_done;   // o_done cycle, start cycle = 0
    } vec_t;

    // Single comparison point: counts, and reports any difference.
    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Drives one frame with a responsive UART model and checks the stream.
    // Inputs are changed and outputs sampled on the falling edge.
    task automatic apply_stimulus(input vec_t v, input string tag);
        int          cyc;
        int          pulses;
        int          sched;
        int          poke_at;
        int          done_cyc;
        logic        finished;
        logic [7:0]  got [3];
        logic [23:0] exp_v;

        sel      = v.sel;
        exp_v    = v.exp;
        pulses   = 0;
        sched    = -1;
        poke_at  = -1;
        done_cyc = -1;
        finished = 1'b0;
        for (int i = 0; i < 3; i++) got[i] = 8'h00;

        if (v.stray) begin
            @(negedge clk);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
        end

        @(negedge clk);
        frame24 = v.frame;
        frame20 = v.frame[19:0];
        if (v.sel) start20 = 1'b1;
        else       start24 = 1'b1;
        cyc = 0;

        while (!finished && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start24 = 1'b0;
            start20 = 1'b0;
            tx_done = 1'b0;
            if (m_tx_start) begin
                if (pulses < 3) got[pulses] = m_tx_data;
                pulses++;
                sched = cyc + v.delay;
                if (v.stray) tx_done = 1'b1;
                if (v.poke && pulses == 2) poke_at = cyc + 1;
            end
            if (cyc == sched && pulses >= 1 && pulses <= 3) begin
                check_output({tag, " hold"}, {24'h0, m_tx_data}, {24'h0, got[pulses-1]});
                tx_done = 1'b1;
            end
            if (cyc == poke_at) begin
                frame24 = 24'h112233;
                frame20 = 20'h12233;
                if (v.sel) start20 = 1'b1;
                else       start24 = 1'b1;
            end
            if (m_done) begin
                done_cyc = cyc;
                finished = 1'b1;
                if (v.poke) begin
                    if (v.sel) start20 = 1'b1;
                    else       start24 = 1'b1;
                end
            end
        end

        check_output({tag, " timeout"}, {31'h0, finished}, 32'h1);
        check_output({tag, " pulses"}, pulses, 3);
        for (int i = 0; i < 3; i++)
            check_output($sformatf("%s byte%0d", tag, i), {24'h0, got[i]}, {24'h0, exp_v[8*i +: 8]});
        check_output({tag, " done_cycle"}, done_cyc, v.exp_done);

        // Cycle after DONE: back to idle, no second done.
        @(negedge clk);
        start24 = 1'b0;
        start20 = 1'b0;
        check_output({tag, " busy_after"}, {31'h0, m_busy}, 32'h0);
        check_output({tag, " done_once"}, {31'h0, m_done}, 32'h0);
        // A start dropped during DONE must not have launched anything.
        @(negedge clk);
        check_output({tag, " idle_start"}, {31'h0, m_tx_start}, 32'h0);
        check_output({tag, " idle_busy"}, {31'h0, m_busy}, 32'h0);
        check_output({tag, " idle_data"}, {24'h0, m_tx_data}, 32'h0);
    endtask

    vec_t vecs [6];

    initial begin
        int   pulses;
        int   sched;
        int   cyc;
        logic seen_done;

        total   = 0;
        bad     = 0;
        sel     = 1'b0;
        rst     = 1'b1;
        start24 = 1'b0;
        start20 = 1'b0;
        tx_done = 1'b0;
        frame24 = '0;
        frame20 = '0;

        vecs[0] = '{sel:1'b0, frame:24'hA1B2C3, delay:3, poke:1'b0, stray:1'b0, exp:24'hA1B2C3, exp_done:13};
        vecs[1] = '{sel:1'b1, frame:24'h0FABCD, delay:2, poke:1'b0, stray:1'b0, exp:24'h0FABCD, exp_done:10};
        vecs[2] = '{sel:1'b0, frame:24'h5A6B7C, delay:1, poke:1'b0, stray:1'b0, exp:24'h5A6B7C, exp_done:7};
        vecs[3] = '{sel:1'b0, frame:24'hA1B2C3, delay:2, poke:1'b1, stray:1'b0, exp:24'hA1B2C3, exp_done:10};
        vecs[4] = '{sel:1'b0, frame:24'h3C4D5E, delay:2, poke:1'b0, stray:1'b1, exp:24'h3C4D5E, exp_done:10};
        vecs[5] = '{sel:1'b0, frame:24'h000102, delay:1, poke:1'b0, stray:1'b0, exp:24'h000102, exp_done:7};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_output("reset tx_start24", {31'h0, tx_start24}, 32'h0);
        check_output("reset tx_data24",  {24'h0, tx_data24},  32'h0);
        check_output("reset busy24",     {31'h0, busy24},     32'h0);
        check_output("reset done24",     {31'h0, done24},     32'h0);
        check_output("reset busy20",     {31'h0, busy20},     32'h0);
        check_output("reset tx_data20",  {24'h0, tx_data20},  32'h0);

        for (int k = 0; k < 5; k++)
            apply_stimulus(vecs[k], $sformatf("vec%0d", k));

        // Reset while waiting on byte 2 of the 24-bit instance.
        $display("[TB] reset mid-frame sequence");
        sel    = 1'b0;
        pulses = 0;
        sched  = -1;
        cyc    = 0;
        @(negedge clk);
        frame24 = 24'hA1B2C3;
        start24 = 1'b1;
        while (pulses < 2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            start24 = 1'b0;
            tx_done = 1'b0;
            if (tx_start24) begin
                pulses++;
                sched = cyc + 3;
            end
            if (cyc == sched) tx_done = 1'b1;
        end
        check_output("rst second_byte", pulses, 2);
        @(negedge clk);
        check_output("rst pre_busy", {31'h0, busy24}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("rst tx_start", {31'h0, tx_start24}, 32'h0);
        check_output("rst tx_data",  {24'h0, tx_data24},  32'h0);
        check_output("rst busy",     {31'h0, busy24},     32'h0);
        check_output("rst done",     {31'h0, done24},     32'h0);
        seen_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done24 || tx_start24 || busy24) seen_done = 1'b1;
        end
        check_output("rst stays_idle", {31'h0, seen_done}, 32'h0);

        apply_stimulus(vecs[5], "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debug_frame_sender.md
Name: debug_frame_sender

Overview:
- Sequences the UART TX datapath for the debug unit.
- On a one-cycle start request from the step/run control FSMs, it snapshots a wide debug frame: clock count, PC, pipeline latches and register file.
- It sends the frame byte by byte through the UART transmitter using a start/done handshake, then pulses a completion flag.
- The step/run FSMs use that completion flag as their send-done input.

Parameters:
- UART_BITS, 8, width of one UART byte.
- FRAME_BITS, 1024, width of the debug frame (concatenation done by the parent).
- N_BYTES, ceil(FRAME_BITS/UART_BITS), derived; bytes per frame.
- CNT_BITS, clog2(N_BYTES)+1, derived; byte counter width.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle send request.
- i_frame  in  FRAME_BITS  debug frame, sampled only when i_start is accepted.
- i_tx_done  in  1  UART TX finished current byte (one-cycle pulse).
- o_tx_start  out  1  one-cycle pulse: UART TX begins sending o_tx_data.
- o_tx_data  out  UART_BITS  byte being sent.
- o_busy  out  1  high from the accepted start through the DONE cycle.
- o_done  out  1  one-cycle pulse after the last byte completes.

Behaviour:
- Reset values: all outputs 0; state IDLE; byte counter 0; shift register 0.
- States:
  - IDLE: o_busy=0. If i_start is high: latch i_frame, zero-padded to N_BYTES*UART_BITS, into the shift register; counter=0; go to SEND.
  - SEND (one cycle): o_tx_start=1; o_tx_data=shift[UART_BITS-1:0]; go to WAIT.
  - WAIT: hold o_tx_data stable; o_tx_start=0.
    - On i_tx_done: shift register right by UART_BITS; counter+1.
    - If counter+1 == N_BYTES, go to DONE; else go to SEND.
  - DONE (one cycle): o_done=1, o_busy=1; go to IDLE.
- Byte order: least significant byte first. The upper pad bits of the last byte are 0.
- Latency:
  - i_start sampled at edge t gives o_tx_start high in cycle t+1.
  - i_tx_done sampled at edge u gives the next o_tx_start in cycle u+1.
  - o_done is high in the cycle after the last i_tx_done.
  - Minimum frame time is 2*N_BYTES+1 cycles after start.
- o_tx_data holds its value from SEND until the following shift. It is 0 in IDLE.
- i_start while o_busy=1, including the DONE cycle, is ignored. No queuing.
- i_tx_done outside WAIT, including in the SEND cycle, is ignored.
- Changes to i_frame after acceptance have no effect on the bytes sent.
- rst mid-frame: immediate return to IDLE with reset values. The partial frame is discarded and no o_done is issued.
- Counter never wraps: its maximum value is N_BYTES.

Decomposition:
- Add to constants.vh:
  - FRAME_BITS, computed as CLK_COUNTER_BITS+PC_BITS+IF_ID_LEN+ID_EX_LEN+EX_MEM_LEN+MEM_WB_LEN+RF_REGS_LEN.
  - State encodings SND_IDLE=0, SND_SEND=1, SND_WAIT=2, SND_DONE=3.
- Single module; no sub-module. The shift register and counter are small enough to stay inline.
- The frame concatenation order is fixed by the debug unit top, not here.

Test Plan:
- Basic frame (FRAME_BITS=24): i_frame=24'hA1B2C3, start pulse, i_tx_done returned 3 cycles after each o_tx_start.
  - Required: o_tx_data sequence C3, B2, A1; exactly 3 o_tx_start pulses; one o_done pulse after the third i_tx_done; o_busy falls the cycle after o_done.
- Padding (FRAME_BITS=20): i_frame=20'hFABCD.
  - Required: bytes CD, AB, 0F.
- Immediate done: i_tx_done asserted in the cycle right after each o_tx_start.
  - Required: o_done exactly 7 cycles after the accepted start (N_BYTES=3).
- Busy protection: second i_start, with i_frame=24'h112233, during byte 2 and again during the DONE cycle; i_frame also changed mid-frame.
  - Required: original bytes sent unaltered; only one o_done; state IDLE afterwards.
- Stray handshakes: i_tx_done pulsed in IDLE and in the SEND cycle.
  - Required: no shift and no counter advance; sent sequence unchanged.
- Reset mid-frame: rst high in WAIT of byte 2 for one cycle.
  - Required: next cycle all outputs 0 and no o_done.
  - A fresh start with 24'h000102 then sends 02, 01, 00 correctly.
